// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : run_sequencer
// Description : Run-control FSM for the PC. Handles start/ack, PC init and
//               jump/branch/stall steering, and counts RUN cycles with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module run_sequencer #(
    parameter int PC_W     = 10,
    parameter int CNT_W    = 16,
    parameter int INIT_CYC = 2,
    parameter int TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ack,
    output logic             busy,
    input  logic             jump_req,
    input  logic             branch_req,
    input  logic             branch_cond,
    input  logic [PC_W-1:0]  target,
    input  logic             stall,
    input  logic             done_req,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             halt_in,
    output logic             pc_init,
    output logic             pc_jump_en,
    output logic             pc_branch_en,
    output logic             pc_done,
    output logic [PC_W-1:0]  pc_dest,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int c_ICW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_ICW-1:0] r_init_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_timeout;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_hit_timeout;

    // Saturating increment; the watchdog fires on the cycle that reaches TIMEOUT
    assign w_count_inc   = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);
    assign w_hit_timeout = (w_count_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_init_cnt <= '0;
            r_count    <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_init_cnt <= '0;
                        r_count    <= '0;
                        r_timeout  <= 1'b0;
                    end
                end
                S_INIT: r_init_cnt <= r_init_cnt + c_ICW'(1);
                S_RUN: begin
                    r_count <= w_count_inc;
                    if (w_hit_timeout) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        pc_init      = 1'b0;
        pc_jump_en   = 1'b0;
        pc_branch_en = 1'b0;
        pc_done      = 1'b0;
        pc_dest      = target;
        busy         = 1'b0;
        ack          = 1'b0;
        case (r_state)
            S_IDLE: begin
                pc_init = 1'b1;
                if (start) begin
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                pc_init = 1'b1;
                busy    = 1'b1;
                if (r_init_cnt == c_ICW'(INIT_CYC - 1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                // A stall reloads the current PC so it holds for this cycle
                if (stall) begin
                    pc_jump_en = 1'b1;
                    pc_dest    = pc_in;
                end else if (jump_req) begin
                    pc_jump_en = 1'b1;
                end else if (branch_req && branch_cond) begin
                    pc_branch_en = 1'b1;
                end
                if (w_hit_timeout) begin
                    w_state_nxt = S_DRAIN;
                end else if (done_req && !stall) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                pc_done = 1'b1;
                if (halt_in) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ack     = 1'b1;
                pc_done = 1'b1;
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign timeout     = r_timeout;
    assign cycle_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_sequencer
// Description : Directed self-checking bench for run_sequencer (TIMEOUT=20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_sequencer;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n, start, jump_req, branch_req, branch_cond;
    logic             stall, done_req, halt_in;
    logic [PC_W-1:0]  target, pc_in;
    logic             ack, busy, pc_init, pc_jump_en, pc_branch_en, pc_done, timeout;
    logic [PC_W-1:0]  pc_dest;
    logic [CNT_W-1:0] cycle_count;

    int checks = 0;
    int errors = 0;

    run_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .INIT_CYC(2), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .busy(busy),
        .jump_req(jump_req), .branch_req(branch_req), .branch_cond(branch_cond),
        .target(target), .stall(stall), .done_req(done_req), .pc_in(pc_in),
        .halt_in(halt_in), .pc_init(pc_init), .pc_jump_en(pc_jump_en),
        .pc_branch_en(pc_branch_en), .pc_done(pc_done), .pc_dest(pc_dest),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "bench time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        jump_req = 0; branch_req = 0; branch_cond = 0; stall = 0;
        done_req = 0; halt_in = 0; target = '0; pc_in = '0;
    endtask

    // start -> INIT (2 cycles) -> RUN after three edges
    task automatic go_run(input string tag);
        start = 1'b1;
        step();
        #1;
        checks++; if (pc_init !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL %s_init pc_init=%0b busy=%0b expected 1 1", tag, pc_init, busy); end
        step();
        step();
        #1;
        checks++; if (pc_init !== 1'b0 || busy !== 1'b1 || pc_done !== 1'b0) begin errors++;
            $display("FAIL %s_run_entry pc_init=%0b busy=%0b pc_done=%0b expected 0 1 0", tag, pc_init, busy, pc_done); end
    endtask

    task automatic finish_run();
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; clear_inputs();
        #12;
        checks++; if (pc_init !== 1'b1 || busy !== 1'b0 || ack !== 1'b0 || pc_done !== 1'b0) begin errors++;
            $display("FAIL reset_outputs pc_init=%0b busy=%0b ack=%0b pc_done=%0b expected 1 0 0 0", pc_init, busy, ack, pc_done); end
        checks++; if (cycle_count !== 16'd0 || timeout !== 1'b0) begin errors++;
            $display("FAIL reset_count count=%0d timeout=%0b expected 0 0", cycle_count, timeout); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_plain_done();
        go_run("plain");
        for (int i = 0; i < 5; i++) begin
            checks++; if (pc_jump_en !== 1'b0 || pc_branch_en !== 1'b0 || pc_done !== 1'b0) begin errors++;
                $display("FAIL plain_cycle%0d jump=%0b branch=%0b done=%0b expected 0 0 0", i, pc_jump_en, pc_branch_en, pc_done); end
            step();
        end
        done_req = 1'b1;
        step();
        done_req = 1'b0;
        #1;
        checks++; if (pc_done !== 1'b1 || ack !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL plain_drain pc_done=%0b ack=%0b busy=%0b expected 1 0 1", pc_done, ack, busy); end
        checks++; if (cycle_count !== 16'd6) begin errors++;
            $display("FAIL plain_count actual=%0d expected=6", cycle_count); end
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        checks++; if (ack !== 1'b1 || busy !== 1'b0 || pc_done !== 1'b1 || cycle_count !== 16'd6) begin errors++;
            $display("FAIL plain_done ack=%0b busy=%0b pc_done=%0b count=%0d expected 1 0 1 6", ack, busy, pc_done, cycle_count); end
        start = 1'b0;
        step();
        checks++; if (ack !== 1'b0 || pc_init !== 1'b1) begin errors++;
            $display("FAIL plain_idle ack=%0b pc_init=%0b expected 0 1", ack, pc_init); end
    endtask

    task automatic test_stall_jump();
        go_run("stall");
        jump_req = 1'b1; target = 10'h2A0; pc_in = 10'h055; stall = 1'b1;
        #1;
        checks++; if (pc_jump_en !== 1'b1 || pc_dest !== 10'h055 || pc_branch_en !== 1'b0) begin errors++;
            $display("FAIL stall_hold jump=%0b dest=%h branch=%0b expected 1 055 0", pc_jump_en, pc_dest, pc_branch_en); end
        step();
        stall = 1'b0;
        #1;
        checks++; if (pc_jump_en !== 1'b1 || pc_dest !== 10'h2A0) begin errors++;
            $display("FAIL stall_release jump=%0b dest=%h expected 1 2a0", pc_jump_en, pc_dest); end
        jump_req = 1'b0; stall = 1'b1; done_req = 1'b1;
        step();
        stall = 1'b0; done_req = 1'b0;
        #1;
        checks++; if (pc_done !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL stall_blocks_done pc_done=%0b busy=%0b expected 0 1", pc_done, busy); end
    endtask

    task automatic test_branch();
        branch_req = 1'b1; branch_cond = 1'b1;
        #1;
        checks++; if (pc_branch_en !== 1'b1 || pc_jump_en !== 1'b0) begin errors++;
            $display("FAIL branch_taken branch=%0b jump=%0b expected 1 0", pc_branch_en, pc_jump_en); end
        branch_cond = 1'b0;
        #1;
        checks++; if (pc_branch_en !== 1'b0 || pc_jump_en !== 1'b0) begin errors++;
            $display("FAIL branch_not_taken branch=%0b jump=%0b expected 0 0", pc_branch_en, pc_jump_en); end
        branch_cond = 1'b1; jump_req = 1'b1; target = 10'h1F3;
        #1;
        checks++; if (pc_jump_en !== 1'b1 || pc_branch_en !== 1'b0 || pc_dest !== 10'h1F3) begin errors++;
            $display("FAIL jump_over_branch jump=%0b branch=%0b dest=%h expected 1 0 1f3", pc_jump_en, pc_branch_en, pc_dest); end
        done_req = 1'b1;
        step();
        clear_inputs();
        #1;
        checks++; if (pc_done !== 1'b1 || pc_jump_en !== 1'b0 || pc_branch_en !== 1'b0) begin errors++;
            $display("FAIL branch_drain pc_done=%0b jump=%0b branch=%0b expected 1 0 0", pc_done, pc_jump_en, pc_branch_en); end
        finish_run();
    endtask

    task automatic test_timeout_hold();
        go_run("wdog");
        for (int i = 0; i < 19; i++) step();
        checks++; if (cycle_count !== 16'd19 || timeout !== 1'b0 || pc_done !== 1'b0) begin errors++;
            $display("FAIL wdog_before count=%0d timeout=%0b pc_done=%0b expected 19 0 0", cycle_count, timeout, pc_done); end
        step();
        checks++; if (cycle_count !== 16'd20 || timeout !== 1'b1 || pc_done !== 1'b1) begin errors++;
            $display("FAIL wdog_fire count=%0d timeout=%0b pc_done=%0b expected 20 1 1", cycle_count, timeout, pc_done); end
        step(); step();
        checks++; if (cycle_count !== 16'd20 || busy !== 1'b1) begin errors++;
            $display("FAIL wdog_frozen count=%0d busy=%0b expected 20 1", cycle_count, busy); end
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ack !== 1'b1 || busy !== 1'b0 || pc_init !== 1'b0) begin errors++;
                $display("FAIL hold_start%0d ack=%0b busy=%0b pc_init=%0b expected 1 0 0", i, ack, busy, pc_init); end
            step();
        end
        start = 1'b0;
        step();
        checks++; if (ack !== 1'b0 || pc_init !== 1'b1 || timeout !== 1'b1) begin errors++;
            $display("FAIL drop_start ack=%0b pc_init=%0b timeout=%0b expected 0 1 1", ack, pc_init, timeout); end
        start = 1'b1;
        step();
        checks++; if (timeout !== 1'b0 || cycle_count !== 16'd0) begin errors++;
            $display("FAIL restart_clear timeout=%0b count=%0d expected 0 0", timeout, cycle_count); end
    endtask

    task automatic test_reset_mid_run();
        step(); step();
        for (int i = 0; i < 3; i++) step();
        checks++; if (cycle_count !== 16'd3 || busy !== 1'b1) begin errors++;
            $display("FAIL midrun_count count=%0d busy=%0b expected 3 1", cycle_count, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (pc_init !== 1'b1 || busy !== 1'b0 || cycle_count !== 16'd0) begin errors++;
            $display("FAIL midrun_reset pc_init=%0b busy=%0b count=%0d expected 1 0 0", pc_init, busy, cycle_count); end
        start = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_plain_done();
        test_stall_jump();
        test_branch();
        test_timeout_hold();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
